score_table_sequencer: RTL

- Sequences the 16-bit scoreboard RAM as a sorted top-DEPTH high-score table.
- Entry i occupies two words: userid at BASE_ADDR+2i and score at BASE_ADDR+2i+1. Entry 0 holds the highest score.
- On an insert request, the block scans the table, shifts lower entries down by one, and writes the new entry.
- It also arbitrates the single RAM port between the insert sequencer and the display's entry-read requests, and clears the table after reset.

---
 rtl/score_table_sequencer_if.sv | 41 ++++
 rtl/score_table_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_table_sequencer_if.sv
// ============================================================================
// Module      : score_table_sequencer_if
// Description : Insert, entry-read and RAM port bundle for score_table_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface score_table_sequencer_if;
  logic        ins_req;
  logic [15:0] ins_userid;
  logic [15:0] ins_score;
  logic        ins_done;
  logic        ins_inserted;
  logic [3:0]  ins_rank;
  logic        rd_req;
  logic [3:0]  rd_idx;
  logic        rd_valid;
  logic [15:0] rd_userid;
  logic [15:0] rd_score;
  logic        busy;
  logic [15:0] address;
  logic [15:0] data;
  logic        wren;
  logic [15:0] ram_data;

  // Sequencer side
  modport slave (
    input  ins_req, ins_userid, ins_score, rd_req, rd_idx, ram_data,
    output ins_done, ins_inserted, ins_rank, rd_valid, rd_userid, rd_score,
           busy, address, data, wren
  );

  // Requester / RAM side
  modport master (
    output ins_req, ins_userid, ins_score, rd_req, rd_idx, ram_data,
    input  ins_done, ins_inserted, ins_rank, rd_valid, rd_userid, rd_score,
           busy, address, data, wren
  );
endinterface

`default_nettype wire

// File: rtl/score_table_sequencer.sv
// ============================================================================
// Module      : score_table_sequencer
// Description : Keeps a sorted top-DEPTH high-score table in a single-port
//               RAM; arbitrates inserts and display entry reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_table_sequencer #(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic                    clk,
  input  logic                    rst,
  score_table_sequencer_if.slave  bus
);

  localparam logic [4:0] LAST_CLR = 5'(2 * DEPTH - 1);
  localparam logic [4:0] LAST_IDX = 5'(DEPTH - 1);
  localparam logic [4:0] SH_START = 5'(DEPTH - 2);
  localparam logic [4:0] DEPTH_W  = 5'(DEPTH);

  typedef enum logic [4:0] {
    S_CLEAR,
    S_IDLE,
    S_RD_ID,
    S_RD_W1,
    S_RD_CID,
    S_RD_W2,
    S_RD_CSC,
    S_RD_DONE,
    S_SC_ADDR,
    S_SC_WAIT,
    S_SC_CAP,
    S_SH_ID,
    S_SH_W1,
    S_SH_CID,
    S_SH_W2,
    S_SH_CSC,
    S_SH_WSC,
    S_WR_ID,
    S_WR_SC,
    S_INS_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  pos_q, pos_d;
  logic [3:0]  ridx_q, ridx_d;
  logic [15:0] uid_q, uid_d;
  logic [15:0] score_q, score_d;
  logic [15:0] tmp_uid_q, tmp_uid_d;
  logic [15:0] tmp_sc_q, tmp_sc_d;
  logic [15:0] address_q, address_d;
  logic [15:0] data_q, data_d;
  logic        wren_q, wren_d;
  logic        ins_done_q, ins_done_d;
  logic        ins_inserted_q, ins_inserted_d;
  logic [3:0]  ins_rank_q, ins_rank_d;
  logic        rd_valid_q, rd_valid_d;
  logic [15:0] rd_userid_q, rd_userid_d;
  logic [15:0] rd_score_q, rd_score_d;

  // Word address of entry idx; sc selects the score word.
  function automatic logic [15:0] entry_addr(input logic [4:0] idx, input logic sc);
    return BASE_ADDR + {10'd0, idx, sc};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_CLEAR;
      cnt_q          <= 5'd0;
      pos_q          <= 4'd0;
      ridx_q         <= 4'd0;
      uid_q          <= 16'd0;
      score_q        <= 16'd0;
      tmp_uid_q      <= 16'd0;
      tmp_sc_q       <= 16'd0;
      address_q      <= BASE_ADDR;
      data_q         <= 16'd0;
      wren_q         <= 1'b0;
      ins_done_q     <= 1'b0;
      ins_inserted_q <= 1'b0;
      ins_rank_q     <= 4'd0;
      rd_valid_q     <= 1'b0;
      rd_userid_q    <= 16'd0;
      rd_score_q     <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pos_q          <= pos_d;
      ridx_q         <= ridx_d;
      uid_q          <= uid_d;
      score_q        <= score_d;
      tmp_uid_q      <= tmp_uid_d;
      tmp_sc_q       <= tmp_sc_d;
      address_q      <= address_d;
      data_q         <= data_d;
      wren_q         <= wren_d;
      ins_done_q     <= ins_done_d;
      ins_inserted_q <= ins_inserted_d;
      ins_rank_q     <= ins_rank_d;
      rd_valid_q     <= rd_valid_d;
      rd_userid_q    <= rd_userid_d;
      rd_score_q     <= rd_score_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pos_d          = pos_q;
    ridx_d         = ridx_q;
    uid_d          = uid_q;
    score_d        = score_q;
    tmp_uid_d      = tmp_uid_q;
    tmp_sc_d       = tmp_sc_q;
    address_d      = address_q;
    data_d         = data_q;
    wren_d         = 1'b0;
    ins_done_d     = 1'b0;
    ins_inserted_d = ins_inserted_q;
    ins_rank_d     = ins_rank_q;
    rd_valid_d     = 1'b0;
    rd_userid_d    = rd_userid_q;
    rd_score_d     = rd_score_q;

    unique case (state_q)
      S_CLEAR: begin
        address_d = BASE_ADDR + {11'd0, cnt_q};
        data_d    = 16'd0;
        wren_d    = 1'b1;
        if (cnt_q == LAST_CLR) begin
          cnt_d   = 5'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_IDLE: begin
        if (bus.rd_req) begin
          ridx_d = bus.rd_idx;
          if ({1'b0, bus.rd_idx} >= DEPTH_W) begin
            rd_userid_d = 16'd0;
            rd_score_d  = 16'd0;
            rd_valid_d  = 1'b1;
            state_d     = S_RD_DONE;
          end else begin
            state_d = S_RD_ID;
          end
        end else if (bus.ins_req) begin
          uid_d   = bus.ins_userid;
          score_d = bus.ins_score;
          cnt_d   = 5'd0;
          state_d = S_SC_ADDR;
        end
      end

      S_RD_ID: begin
        address_d = entry_addr({1'b0, ridx_q}, 1'b0);
        state_d   = S_RD_W1;
      end
      S_RD_W1: state_d = S_RD_CID;
      S_RD_CID: begin
        tmp_uid_d = bus.ram_data;
        address_d = entry_addr({1'b0, ridx_q}, 1'b1);
        state_d   = S_RD_W2;
      end
      S_RD_W2: state_d = S_RD_CSC;
      S_RD_CSC: begin
        rd_userid_d = tmp_uid_q;
        rd_score_d  = bus.ram_data;
        rd_valid_d  = 1'b1;
        state_d     = S_RD_DONE;
      end
      S_RD_DONE: state_d = S_IDLE;

      S_SC_ADDR: begin
        address_d = entry_addr(cnt_q, 1'b1);
        state_d   = S_SC_WAIT;
      end
      S_SC_WAIT: state_d = S_SC_CAP;
      S_SC_CAP: begin
        // Strict compare: an equal score ranks below the entry already there.
        if (score_q > bus.ram_data) begin
          pos_d = cnt_q[3:0];
          if (cnt_q == LAST_IDX) begin
            state_d = S_WR_ID;
          end else begin
            cnt_d   = SH_START;
            state_d = S_SH_ID;
          end
        end else if (cnt_q == LAST_IDX) begin
          ins_done_d     = 1'b1;
          ins_inserted_d = 1'b0;
          ins_rank_d     = DEPTH_W[3:0];
          state_d        = S_INS_DONE;
        end else begin
          cnt_d   = cnt_q + 5'd1;
          state_d = S_SC_ADDR;
        end
      end

      S_SH_ID: begin
        address_d = entry_addr(cnt_q, 1'b0);
        state_d   = S_SH_W1;
      end
      S_SH_W1: state_d = S_SH_CID;
      S_SH_CID: begin
        tmp_uid_d = bus.ram_data;
        address_d = entry_addr(cnt_q, 1'b1);
        state_d   = S_SH_W2;
      end
      S_SH_W2: state_d = S_SH_CSC;
      S_SH_CSC: begin
        tmp_sc_d  = bus.ram_data;
        address_d = entry_addr(cnt_q + 5'd1, 1'b0);
        data_d    = tmp_uid_q;
        wren_d    = 1'b1;
        state_d   = S_SH_WSC;
      end
      S_SH_WSC: begin
        address_d = entry_addr(cnt_q + 5'd1, 1'b1);
        data_d    = tmp_sc_q;
        wren_d    = 1'b1;
        if (cnt_q == {1'b0, pos_q}) begin
          state_d = S_WR_ID;
        end else begin
          cnt_d   = cnt_q - 5'd1;
          state_d = S_SH_ID;
        end
      end

      S_WR_ID: begin
        address_d = entry_addr({1'b0, pos_q}, 1'b0);
        data_d    = uid_q;
        wren_d    = 1'b1;
        state_d   = S_WR_SC;
      end
      S_WR_SC: begin
        address_d      = entry_addr({1'b0, pos_q}, 1'b1);
        data_d         = score_q;
        wren_d         = 1'b1;
        ins_done_d     = 1'b1;
        ins_inserted_d = 1'b1;
        ins_rank_d     = pos_q;
        state_d        = S_INS_DONE;
      end
      S_INS_DONE: state_d = S_IDLE;

      default: begin
        cnt_d   = 5'd0;
        state_d = S_CLEAR;
      end
    endcase
  end

  assign bus.address      = address_q;
  assign bus.data         = data_q;
  assign bus.wren         = wren_q;
  assign bus.ins_done     = ins_done_q;
  assign bus.ins_inserted = ins_inserted_q;
  assign bus.ins_rank     = ins_rank_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_userid    = rd_userid_q;
  assign bus.rd_score     = rd_score_q;
  assign bus.busy         = (state_q != S_IDLE);

endmodule

`default_nettype wire
